// File: rtl/instr_encoder_pkg.sv
// Shared instruction-set constants: the in_kind request codes and the primary opcodes.
// The processor control unit's decode imports this package too.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_LW    = 3'b000,
        KIND_SW    = 3'b001,
        KIND_BEQ   = 3'b010,
        KIND_BNE   = 3'b011,
        KIND_RTYPE = 3'b100
    } kind_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_RTYPE = 6'b000000;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: request kind and fields in, 32-bit MIPS word out.
// valid is low for the unused kind codes 101-111.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o,
    output logic        valid_o
);

    always_comb begin
        word_o  = '0;
        valid_o = 1'b1;
        case (kind_i)
            KIND_LW:    word_o = {OP_LW,  rs_i, rt_i, imm_i};
            KIND_SW:    word_o = {OP_SW,  rs_i, rt_i, imm_i};
            KIND_BEQ:   word_o = {OP_BEQ, rs_i, rt_i, imm_i};
            KIND_BNE:   word_o = {OP_BNE, rs_i, rt_i, imm_i};
            KIND_RTYPE: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            default:    valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests and streams them into instruction memory at
// consecutive word addresses, stopping once DEPTH words have been written.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [31:0]        pack_word;
    logic               pack_valid;
    logic               accept;

    instr_pack u_pack (
        .kind_i  (in_kind),
        .rs_i    (in_rs),
        .rt_i    (in_rt),
        .rd_i    (in_rd),
        .funct_i (in_funct),
        .imm_i   (in_imm),
        .word_o  (pack_word),
        .valid_o (pack_valid)
    );

    assign full     = (state_q == ST_FULL);
    assign in_ready = !full && !clear;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        // clear never touches we_q, so a write accepted last cycle still lands
        if (clear) begin
            state_d = ST_FILL;
            ptr_d   = '0;
            count_d = '0;
        end else if (accept) begin
            if (pack_valid) begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = pack_word;
                count_d = count_q + 1'b1;
                if (ptr_q == LAST) state_d = ST_FULL;
                else               ptr_d   = ptr_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign err        = err_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4): the driver predicts writes and
// error pulses into a queue; the monitor pops them as the DUT produces outputs.
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    typedef struct {
        bit          is_err;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs, in_rt, in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int errors = 0;
    int checks = 0;

    exp_t q[$];
    int   m_ptr, m_count;
    bit   m_full;
    logic [31:0] last_addr, last_wdata;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_funct   (in_funct),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoding built from the instruction-format rules with plain arithmetic.
    function automatic bit ref_enc(input int k, input int rs, input int rt, input int rd,
                                   input int fn, input int imm, output logic [31:0] w);
        int op;
        w = 32'h0;
        case (k)
            0: op = 35;
            1: op = 43;
            2: op = 4;
            3: op = 5;
            4: op = 0;
            default: return 1'b0;
        endcase
        if (k == 4) w = 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + fn);
        else        w = 32'(op * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm);
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_count = 0; m_full = 0;
        last_addr = 0; last_wdata = 0;
        q.delete();
    endtask

    // Called at posedge+1; occupies exactly one clock cycle.
    task automatic drive(input bit v, input int k, input int rs, input int rt, input int rd,
                         input int fn, input int imm, input bit clr);
        bit          acc, ok;
        logic [31:0] w;
        exp_t        e;
        in_valid = v; clear = clr; in_kind = 3'(k);
        in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_funct = 6'(fn); in_imm = 16'(imm);
        #1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, !m_full && !clr});
        acc = v && !m_full && !clr;
        @(posedge clk);
        if (clr) begin
            m_ptr = 0; m_count = 0; m_full = 0;
        end else if (acc) begin
            ok = ref_enc(k, rs, rt, rd, fn, imm, w);
            if (ok) begin
                e.is_err = 0; e.addr = 32'(m_ptr); e.wdata = w;
                q.push_back(e);
                m_count++;
                if (m_ptr == DEPTH - 1) m_full = 1;
                else                    m_ptr++;
            end else begin
                e.is_err = 1; e.addr = 0; e.wdata = 0;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            chk("count", 32'(count), 32'(m_count));
            chk("full", {31'b0, full}, {31'b0, m_full});
            if (imem_we) begin
                if (q.size() == 0 || q[0].is_err) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("imem_addr", 32'(imem_addr), e.addr);
                    chk("imem_wdata", imem_wdata, e.wdata);
                    last_addr = e.addr; last_wdata = e.wdata;
                end
            end else begin
                chk("addr_hold", 32'(imem_addr), last_addr);
                chk("wdata_hold", imem_wdata, last_wdata);
            end
            if (err) begin
                if (q.size() == 0 || !q[0].is_err) chk("unexpected_err", 32'd1, 32'd0);
                else void'(q.pop_front());
            end
        end
    end

    initial begin
        rst = 1; clear = 0; in_valid = 0; in_kind = 0;
        in_rs = 0; in_rt = 0; in_rd = 0; in_funct = 0; in_imm = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {31'b0, imem_we}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        rst = 0;

        // lw at pointer 0
        drive(1, 0, 1, 2, 0, 0, 16'h0004, 0);
        chk("lw_we", {31'b0, imem_we}, 32'd1);
        chk("lw_addr", 32'(imem_addr), 32'd0);
        chk("lw_wdata", imem_wdata, 32'h8C220004);
        chk("lw_count", 32'(count), 32'd1);

        // back-to-back sw then R-type
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 3, 4, 0, 0, 16'hFFFC, 0);
        chk("sw_wdata", imem_wdata, 32'hAC64FFFC);
        chk("sw_addr", 32'(imem_addr), 32'd0);
        drive(1, 4, 1, 2, 3, 6'h20, 0, 0);
        chk("r_we", {31'b0, imem_we}, 32'd1);
        chk("r_wdata", imem_wdata, 32'h00221820);
        chk("r_addr", 32'(imem_addr), 32'd1);

        // beq then invalid kind
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 2, 1, 1, 0, 0, 16'hFFFF, 0);
        chk("beq_wdata", imem_wdata, 32'h1021FFFF);
        drive(1, 7, 5, 6, 7, 1, 16'h1234, 0);
        chk("inv_we", {31'b0, imem_we}, 32'd0);
        chk("inv_err", {31'b0, err}, 32'd1);
        chk("inv_count", 32'(count), 32'd1);
        idle();
        chk("err_one_cycle", {31'b0, err}, 32'd0);

        // fill to DEPTH, hold, clear
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) drive(1, 0, i, i + 1, 0, 0, i * 4, 0);
        chk("full_set", {31'b0, full}, 32'd1);
        chk("full_ready", {31'b0, in_ready}, 32'd0);
        drive(1, 1, 9, 9, 0, 0, 16'h0008, 0);
        chk("held_we", {31'b0, imem_we}, 32'd0);
        chk("held_count", 32'(count), 32'(DEPTH));
        drive(1, 1, 9, 9, 0, 0, 16'h0008, 1);
        chk("clr_full", {31'b0, full}, 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        drive(1, 3, 2, 3, 0, 0, 16'h0010, 0);
        chk("after_clr_addr", 32'(imem_addr), 32'd0);
        chk("after_clr_we", {31'b0, imem_we}, 32'd1);

        // write accepted, then clear: write still completes
        drive(1, 0, 4, 5, 0, 0, 16'h0020, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // reset between acceptance and write
        in_valid = 1; in_kind = 0; in_rs = 1; in_rt = 2; in_imm = 16'h0040;
        @(posedge clk);
        #1;
        rst = 1; in_valid = 0;
        model_reset();
        #1;
        chk("rstmid_we", {31'b0, imem_we}, 32'd0);
        chk("rstmid_addr", 32'(imem_addr), 32'd0);
        chk("rstmid_wdata", imem_wdata, 32'd0);
        chk("rstmid_count", 32'(count), 32'd0);
        chk("rstmid_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        idle();
        chk("post_rst_we", {31'b0, imem_we}, 32'd0);

        // randomized traffic
        repeat (400) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                  $urandom_range(0, 65535), $urandom_range(0, 11) == 0);
        end
        idle();
        idle();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
